// File: rtl/frame_reader_if.sv
// rtl/frame_reader_if.sv - DDR2 request/response and pixel-stream bundle for frame_reader
//
// Signals:
//   FF_frame_base  frame base; bits [27:22] select the frame
//   af_full        DDR2 address FIFO full
//   af_wr_en       address FIFO push
//   af_addr_din    31-bit read address
//   af_cmd_din     DDR2 command (read)
//   rdf_valid      read-data word present (no back-pressure)
//   rdf_dout       128-bit read-data word, 4 pixels
//   rdf_rd_en      read-data FIFO pop
//   video_ready    pixel sink accepts
//   video_valid    pixel valid
//   video          24-bit pixel colour
//   video_sof      first pixel of a frame
//   rdf_overflow   sticky: word arrived with no outstanding request
// Modports: master = frame_reader side, slave = DDR2 controller / pixel sink side.
interface frame_reader_if;
  logic [31:0]  FF_frame_base;
  logic         af_full;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic [2:0]   af_cmd_din;
  logic         rdf_valid;
  logic [127:0] rdf_dout;
  logic         rdf_rd_en;
  logic         video_ready;
  logic         video_valid;
  logic [23:0]  video;
  logic         video_sof;
  logic         rdf_overflow;

  modport master (
    input  FF_frame_base, af_full, rdf_valid, rdf_dout, video_ready,
    output af_wr_en, af_addr_din, af_cmd_din, rdf_rd_en,
           video_valid, video, video_sof, rdf_overflow
  );

  modport slave (
    output FF_frame_base, af_full, rdf_valid, rdf_dout, video_ready,
    input  af_wr_en, af_addr_din, af_cmd_din, rdf_rd_en,
           video_valid, video, video_sof, rdf_overflow
  );
endinterface

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - fetches a frame from DDR2 in 8-pixel bursts and streams it out in raster order
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  frame_reader_if.master: DDR2 address/read-data FIFOs and the pixel stream
// Parameters:
//   WIDTH      pixels per line (multiple of 8)
//   HEIGHT     lines per frame
//   BUF_DEPTH  read-data buffer depth in 128-bit words (even, >= 4)
module frame_reader #(
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int BUF_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  frame_reader_if.master bus
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Wide enough for out_cnt + buf_cnt, each of which can reach BUF_DEPTH.
  localparam int CW = $clog2(2 * BUF_DEPTH + 1);

  localparam logic [9:0]    RX_LAST  = 10'(WIDTH - 8);
  localparam logic [9:0]    Y_LAST   = 10'(HEIGHT - 1);
  localparam logic [9:0]    OX_LAST  = 10'(WIDTH - 1);
  localparam logic [CW-1:0] CREDIT   = CW'(BUF_DEPTH - 2);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [5:0]    frame;
  logic [9:0]    rx, ry, ox, oy;
  logic [1:0]    lane;
  logic [CW-1:0] out_cnt, buf_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          overflow;
  logic [127:0]  mem [BUF_DEPTH];

  logic          push, word_in, has_data, fire, pop, last_pix;
  logic [127:0]  head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A request is only issued when the buffer can absorb both of its words on
  // top of everything already in flight, so the buffer can never overflow.
  assign push     = ~rst & (state == RUN) & ~bus.af_full & ((out_cnt + buf_cnt) <= CREDIT);
  assign word_in  = bus.rdf_valid & (out_cnt != '0);
  assign has_data = ~rst & (buf_cnt != '0);
  assign fire     = has_data & bus.video_ready;
  assign pop      = fire & (lane == 2'd3);
  assign last_pix = fire & (ox == OX_LAST) & (oy == Y_LAST);
  assign head     = mem[rd_ptr];

  assign bus.af_wr_en     = push;
  assign bus.af_addr_din  = rst ? '0 : {6'b0, frame, ry, rx[9:3], 2'b00};
  assign bus.af_cmd_din   = 3'b001;
  assign bus.rdf_rd_en    = bus.rdf_valid;
  assign bus.video_valid  = has_data;
  assign bus.video        = has_data ? head[{lane, 5'b00000} +: 24] : '0;
  assign bus.video_sof    = has_data & (ox == '0) & (oy == '0);
  assign bus.rdf_overflow = overflow;

  logic unused_bits;
  assign unused_bits = ^{bus.FF_frame_base[31:28], bus.FF_frame_base[21:0], rx[2:0]};

  // Request FSM. The frame register is only loaded on entry to a frame, so a
  // base change mid-frame takes effect at the next frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frame <= '0;
      rx    <= '0;
      ry    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          frame <= bus.FF_frame_base[27:22];
        end
        RUN: begin
          if (push) begin
            if (rx == RX_LAST) begin
              rx <= '0;
              if (ry == Y_LAST) begin
                ry    <= '0;
                state <= DRAIN;
              end else begin
                ry <= ry + 10'd1;
              end
            end else begin
              rx <= rx + 10'd8;
            end
          end
        end
        DRAIN: begin
          if (last_pix) begin
            state <= RUN;
            frame <= bus.FF_frame_base[27:22];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit, buffer bookkeeping and output position.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt  <= '0;
      buf_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lane     <= '0;
      ox       <= '0;
      oy       <= '0;
      overflow <= 1'b0;
    end else begin
      out_cnt <= out_cnt + (push ? CW'(2) : CW'(0)) - (word_in ? CW'(1) : CW'(0));
      buf_cnt <= buf_cnt + (word_in ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      if (bus.rdf_valid && out_cnt == '0) overflow <= 1'b1;
      if (word_in) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      if (fire) begin
        lane <= lane + 2'd1;
        if (ox == OX_LAST) begin
          ox <= '0;
          oy <= (oy == Y_LAST) ? '0 : oy + 10'd1;
        end else begin
          ox <= ox + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_in) mem[wr_ptr] <= bus.rdf_dout;
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - self-checking bench for frame_reader with a DDR2 response model
module tb_frame_reader;
  localparam int W    = 32;
  localparam int H    = 3;
  localparam int D    = 8;
  localparam int FPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_reader_if bus ();

  frame_reader #(.WIDTH(W), .HEIGHT(H), .BUF_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        full;
    logic        rv;
    logic        exp_wr;
    logic [30:0] exp_addr;
    logic        exp_rd;
    logic        exp_vv;
  } vec_t;

  typedef struct {
    int           t;
    logic [127:0] d;
  } ddr_t;

  ddr_t        ddr_q[$];
  logic [23:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int         m_out, m_buf, m_rx, m_ry, m_lane, pix_total, pix_frame;
  logic [5:0] m_frame;
  logic       m_ovf;
  logic       prev_hold;
  logic [23:0] prev_video;
  logic       prev_sof;

  int lat_lo = 5, lat_hi = 5;
  bit model_en = 1'b0, inject = 1'b0, rand_full = 1'b0, rst_req = 1'b0;
  int ready_mode = 1;
  int push_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
  endtask

  function automatic logic [30:0] mk_addr(input logic [5:0] f, input int y, input int xf);
    return {6'b0, f, 10'(y), 7'(xf), 2'b00};
  endfunction

  function automatic logic [127:0] mk_word(input int y, input int x);
    logic [127:0] w;
    for (int k = 0; k < 4; k++)
      w[32*k +: 32] = {8'hA0 | 8'(k), 24'((y << 10) | (x + k))};
    return w;
  endfunction

  task automatic model_reset();
    ddr_q.delete();
    exp_q.delete();
    m_out = 0; m_buf = 0; m_rx = 0; m_ry = 0; m_lane = 0; pix_frame = 0;
    m_frame = bus.FF_frame_base[27:22];
    m_ovf = 1'b0;
    prev_hold = 1'b0;
  endtask

  task automatic drive_inputs();
    ddr_t e;
    cyc++;
    rst = rst_req;
    bus.rdf_valid = 1'b0;
    bus.rdf_dout  = '0;
    if (inject) begin
      bus.rdf_valid = 1'b1;
      bus.rdf_dout  = {4{32'hDEAD_BEEF}};
    end else if (model_en && ddr_q.size() > 0 && ddr_q[0].t <= cyc) begin
      e = ddr_q.pop_front();
      bus.rdf_valid = 1'b1;
      bus.rdf_dout  = e.d;
      for (int k = 0; k < 4; k++) exp_q.push_back(e.d[32*k +: 24]);
    end
    bus.af_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.video_ready = (ready_mode == 0) ? 1'b0 :
                      (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic observe();
    int lat, y, x;
    if (rst) return;
    chk("rdf_rd_en", 32'(bus.rdf_rd_en), 32'(bus.rdf_valid));
    chk("rdf_overflow", 32'(bus.rdf_overflow), 32'(m_ovf));
    chk("video_valid", 32'(bus.video_valid), 32'(m_buf != 0));
    chk("wr_while_full", 32'(bus.af_wr_en & bus.af_full), 32'd0);
    if (prev_hold) begin
      chk("hold_video", 32'(bus.video), 32'(prev_video));
      chk("hold_sof", 32'(bus.video_sof), 32'(prev_sof));
    end
    if (!bus.video_valid) chk("idle_video", 32'({bus.video_sof, bus.video}), 32'd0);
    if (bus.rdf_valid) begin
      if (m_out > 0) begin
        m_out--;
        m_buf++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (bus.af_wr_en) begin
      chk("addr", 32'(bus.af_addr_din), 32'(mk_addr(m_frame, m_ry, m_rx / 8)));
      chk("credit", 32'(m_out + m_buf <= D - 2), 32'd1);
      y   = int'(bus.af_addr_din[18:9]);
      x   = int'(bus.af_addr_din[8:2]) * 8;
      lat = int'($urandom_range(lat_lo, lat_hi));
      ddr_q.push_back('{t: cyc + lat, d: mk_word(y, x)});
      ddr_q.push_back('{t: cyc + lat + 1, d: mk_word(y, x + 4)});
      m_out += 2;
      push_cnt++;
      m_rx += 8;
      if (m_rx == W) begin
        m_rx = 0;
        m_ry = (m_ry == H - 1) ? 0 : m_ry + 1;
      end
    end
    if (bus.video_valid && bus.video_ready) begin
      if (exp_q.size() == 0) fail("pixel_unexpected");
      else chk("pixel", 32'(bus.video), 32'(exp_q.pop_front()));
      chk("sof", 32'(bus.video_sof), 32'(pix_frame == 0));
      pix_total++;
      pix_frame++;
      if (pix_frame == FPIX) begin
        pix_frame = 0;
        m_frame = bus.FF_frame_base[27:22];
      end
      m_lane = (m_lane + 1) % 4;
      if (m_lane == 0) m_buf--;
    end
    prev_hold  = bus.video_valid & ~bus.video_ready;
    prev_video = bus.video;
    prev_sof   = bus.video_sof;
  endtask

  task automatic cyc_step();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    observe();
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (pix_total < target && n < budget) begin
      cyc_step();
      n++;
    end
    if (pix_total < target) fail("pixel_timeout");
  endtask

  initial begin
    logic [31:0] base0, base1;
    logic [5:0]  f0;
    vec_t        tbl[9];
    int          cnt, n;

    base0 = 32'h0AC0_0000;
    base1 = 32'h0540_0000;
    f0    = base0[27:22];

    bus.FF_frame_base = base0;
    bus.af_full       = 1'b0;
    bus.rdf_valid     = 1'b0;
    bus.rdf_dout      = '0;
    bus.video_ready   = 1'b1;
    pix_total         = 0;
    model_reset();

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 31'd0,              1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 31'd0,              1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 31'd0,              1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, mk_addr(f0, 0, 0), 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, mk_addr(f0, 0, 1), 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, mk_addr(f0, 0, 2), 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, mk_addr(f0, 0, 2), 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, mk_addr(f0, 0, 3), 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, mk_addr(f0, 1, 0), 1'b0, 1'b0};

    // Reset and request start-up, one table row per cycle.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      rst             = tbl[i].rst;
      rst_req         = tbl[i].rst;
      bus.af_full     = tbl[i].full;
      bus.rdf_valid   = tbl[i].rv;
      bus.rdf_dout    = '0;
      bus.video_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("t%0d_af_wr_en", i), 32'(bus.af_wr_en), 32'(tbl[i].exp_wr));
      chk($sformatf("t%0d_af_addr", i), 32'(bus.af_addr_din), 32'(tbl[i].exp_addr));
      chk($sformatf("t%0d_af_cmd", i), 32'(bus.af_cmd_din), 32'd1);
      chk($sformatf("t%0d_rdf_rd_en", i), 32'(bus.rdf_rd_en), 32'(tbl[i].exp_rd));
      chk($sformatf("t%0d_video_valid", i), 32'(bus.video_valid), 32'(tbl[i].exp_vv));
      chk($sformatf("t%0d_video", i), 32'({bus.video_sof, bus.video}), 32'd0);
      observe();
    end

    // Free-running sink; base changes mid-frame and must apply from the next frame.
    model_en = 1'b1;
    run_until(40, 2000);
    bus.FF_frame_base = base1;
    run_until(2 * FPIX + 10, 4000);

    // Stalled sink: requests must stop once credit is exhausted.
    ready_mode = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc_step();
      if (i >= 25 && bus.af_wr_en) cnt++;
    end
    chk("stall_no_push", 32'(cnt), 32'd0);
    n = 0;
    while ((ddr_q.size() > 0 || m_out > 0) && n < 200) begin
      cyc_step();
      n++;
    end
    if (n >= 200) fail("drain_timeout");

    // Spurious word with nothing outstanding is dropped and flagged.
    inject = 1'b1;
    cyc_step();
    inject = 1'b0;
    cyc_step();
    chk("overflow_set", 32'(bus.rdf_overflow), 32'd1);
    ready_mode = 1;
    run_until(pix_total + FPIX, 4000);
    chk("overflow_sticky", 32'(bus.rdf_overflow), 32'd1);

    // Random address-FIFO full, random latency and random sink.
    rand_full  = 1'b1;
    lat_lo     = 5;
    lat_hi     = 30;
    ready_mode = 2;
    run_until(pix_total + 2 * FPIX + 17, 20000);

    // Mid-frame reset abandons everything in flight.
    rst_req = 1'b1;
    cyc_step();
    cyc_step();
    model_reset();
    rst_req    = 1'b0;
    rand_full  = 1'b0;
    ready_mode = 1;
    lat_lo     = 5;
    lat_hi     = 12;
    cyc_step();
    chk("post_reset_overflow", 32'(bus.rdf_overflow), 32'd0);
    chk("post_reset_af_wr_en", 32'(bus.af_wr_en), 32'd0);
    chk("post_reset_addr", 32'(bus.af_addr_din), 32'd0);
    run_until(pix_total + FPIX + 5, 4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter WIDTH, default 800; pixels per line, a multiple of 8.
REQ-002 Parameter HEIGHT, default 600; lines per frame.
REQ-003 Parameter BUF_DEPTH, default 8; depth of the internal read-data buffer in 128-bit words, even and at least 4.
REQ-004 clk  in  1  system clock; one clock domain; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 FF_frame_base  in  32  frame base; bits [27:22] select the frame.
REQ-007 af_full  in  1  DDR2 address FIFO full.
REQ-008 af_wr_en  out  1  address FIFO push.
REQ-009 af_addr_din  out  31  read address.
REQ-010 af_cmd_din  out  3  DDR2 command; constant 3'b001 (read).
REQ-011 rdf_valid  in  1  DDR2 read-data word present; cannot be back-pressured.
REQ-012 rdf_dout  in  128  read-data word; 4 pixels.
REQ-013 rdf_rd_en  out  1  read-data FIFO pop.
REQ-014 video_ready  in  1  pixel sink accepts.
REQ-015 video_valid  out  1  pixel valid.
REQ-016 video  out  24  pixel colour.
REQ-017 video_sof  out  1  qualifies pixel (0,0) of a frame.
REQ-018 rdf_overflow  out  1  sticky error: a word arrived with no outstanding request.

Function
REQ-019 The states SHALL be IDLE, RUN and DRAIN; IDLE SHALL advance to RUN unconditionally on the next cycle, latching FF_frame_base[27:22] into the frame register.
REQ-020 Request counters rx (step 8, range 0..WIDTH-8) and ry (range 0..HEIGHT-1) SHALL form af_addr_din = {6'b0, frame[5:0], ry[9:0], rx[9:3], 2'b00}.
REQ-021 Each address command SHALL fetch exactly two rdf words (8 pixels), in ascending x order.
REQ-022 af_wr_en SHALL be asserted combinationally when state is RUN, af_full is 0, and out_cnt + buf_cnt <= BUF_DEPTH-2.
REQ-023 On each push, rx SHALL advance by 8; at rx = WIDTH-8 it SHALL wrap to 0 and ry SHALL increment.
REQ-024 The push at (WIDTH-8, HEIGHT-1) SHALL move the state to DRAIN and clear rx and ry.
REQ-025 DRAIN SHALL hold af_wr_en at 0 until the last pixel of the frame is accepted on the video port.
REQ-026 On that same cycle, DRAIN SHALL go to RUN and relatch the frame register from FF_frame_base; the base therefore changes only at frame boundaries.
REQ-027 rdf_rd_en SHALL equal rdf_valid in every cycle.
REQ-028 out_cnt (0..BUF_DEPTH) SHALL increase by 2 on each push and decrease by 1 on each rdf word; a push and a word in the same cycle SHALL give a net +1.
REQ-029 A word arriving with out_cnt = 0 SHALL be discarded and SHALL set rdf_overflow; rdf_overflow SHALL clear only on rst.
REQ-030 Accepted words SHALL be written to a BUF_DEPTH-word FIFO; the credit rule (REQ-022) guarantees this FIFO never overflows.
REQ-031 A word written in cycle N SHALL be visible on video in cycle N+1.
REQ-032 video_valid SHALL be 1 whenever the buffer is non-empty.
REQ-033 video SHALL be lane k = head word bits [32k+23:32k], k = 0..3 in order; bits [32k+31:32k+24] SHALL be ignored; video SHALL be 0 when video_valid is 0.
REQ-034 The lane SHALL advance on video_valid & video_ready; the head word SHALL be popped after lane 3 is accepted.
REQ-035 A pop and a push to the buffer in the same cycle SHALL both take effect.
REQ-036 Output counters ox/oy SHALL track the pixel position and wrap at WIDTH-1 and HEIGHT-1.
REQ-037 video_sof SHALL be video_valid & (ox = 0) & (oy = 0).
REQ-038 Without video_ready, video and video_sof SHALL hold stable.

Reset
REQ-039 On rst, the state SHALL go to IDLE.
REQ-040 On rst, these SHALL be zeroed: rx, ry, ox, oy, lane, out_cnt, buffer pointers, the frame register and rdf_overflow.
REQ-041 During rst and in the cycle after rst: af_wr_en = 0, af_addr_din = 0, video_valid = 0, video = 0, video_sof = 0, and rdf_rd_en = rdf_valid.
REQ-042 Asserting rst mid-frame SHALL abandon all outstanding requests and buffered data.
REQ-043 The system SHALL reset the DDR2 controller together with this block.

Verification
REQ-044 Reset then free-running sink with af_full = 0: first af_wr_en occurs 1 cycle after rst deasserts, with addr {6'b0, base[27:22], 10'd0, 7'd0, 2'b00}; the fourth push carries x field 7'd3.
REQ-045 Full 800x600 frame through a DDR2 model, with pixel = (y<<10)|x: exactly 480000 pixels in raster order; video_sof only on the first pixel; 60000 pushes.
REQ-046 video_ready held at 0: pushes stop when out_cnt + buf_cnt > BUF_DEPTH-2; buffer never exceeds BUF_DEPTH; no pixel is lost after release.
REQ-047 af_full toggled randomly and rdf latency 5-30 cycles: pixel stream is identical to REQ-045; af_wr_en is never 1 while af_full is 1.
REQ-048 FF_frame_base changed mid-frame: the current frame keeps the old bits [27:22]; the first push of the next frame uses the new bits.
REQ-049 Spurious rdf_valid with out_cnt = 0: word is dropped and rdf_overflow is 1 until rst.
